// File: rtl/channel_pkg.sv
// Shared types and constants for the channel readout block: FSM encoding,
// frame geometry and header field widths.
package channel_pkg;

  localparam int HDR_BYTES  = 3;
  localparam int FIFO_DEPTH = 256;
  localparam int TS_W       = 13;
  localparam int LEN_W      = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    HDR     = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    DATA    = 3'd5,
    FIN     = 3'd6
  } state_e;

  function automatic logic [LEN_W-1:0] min_len(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // First header byte: echo flag, two reserved zeros, timestamp high bits.
  function automatic logic [7:0] hdr_first(input logic flag, input logic [TS_W-1:0] ts);
    return {flag, 2'b00, ts[TS_W-1:8]};
  endfunction

endpackage

// File: rtl/channel_readout.sv
// Streams one recording channel as a byte frame: a small header (flag,
// timestamp, sample count) followed by the samples pulled from the channel FIFO.
module channel_readout #(
  parameter int HDR_BYTES  = channel_pkg::HDR_BYTES,
  parameter int FIFO_DEPTH = channel_pkg::FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          readout_start,
  input  logic                          echo_pulse_detected,
  input  logic [channel_pkg::LEN_W-1:0] sample_length,
  input  logic [channel_pkg::TS_W-1:0]  timestamp,
  input  logic [7:0]                    fifo_usdw,
  input  logic [7:0]                    fifo_q,
  output logic                          fifo_read_request,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);
  import channel_pkg::*;

  localparam int                AVAIL_MAX_I = (FIFO_DEPTH > 255) ? 255 : FIFO_DEPTH;
  localparam logic [LEN_W-1:0]  AVAIL_MAX   = LEN_W'(AVAIL_MAX_I);
  localparam logic [7:0]        HDR_LAST    = 8'(HDR_BYTES - 1);

  state_e           state_q, state_d;
  logic [7:0]       ts_lo_q, ts_lo_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       hdr_idx_q, hdr_idx_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_req_q, rd_req_d;
  logic [LEN_W-1:0] avail;
  logic [7:0]       hdr_nxt_idx;
  logic             xfer;

  // The usdw word is clamped to what the FIFO can actually hold.
  assign avail       = min_len(fifo_usdw, AVAIL_MAX);
  assign hdr_nxt_idx = hdr_idx_q + 8'd1;
  assign xfer        = out_valid_q & out_ready;

  // Bytes after the first; the flag and timestamp high bits go straight
  // into out_data at LATCH, so only the low timestamp byte is kept.
  function automatic logic [7:0] hdr_byte(input logic [7:0] idx);
    logic [7:0] b;
    b = cnt_q;
    if (idx == 8'd1) b = ts_lo_q;
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    ts_lo_d    = ts_lo_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    hdr_idx_d  = hdr_idx_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d = out_last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_req_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (readout_start) begin
          state_d = LATCH;
          busy_d  = 1'b1;
        end
      end

      LATCH: begin
        ts_lo_d     = timestamp[7:0];
        cnt_d       = min_len(sample_length, avail);
        rem_d       = min_len(sample_length, avail);
        hdr_idx_d   = 8'd0;
        out_data_d  = hdr_first(echo_pulse_detected, timestamp);
        out_valid_d = 1'b1;
        out_last_d  = (HDR_LAST == 8'd0) && (min_len(sample_length, avail) == '0);
        state_d     = HDR;
      end

      HDR: begin
        if (xfer) begin
          if (hdr_idx_q == HDR_LAST) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (cnt_q == '0) begin
              state_d = FIN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d  = RD_REQ;
              rd_req_d = 1'b1;
            end
          end else begin
            hdr_idx_d  = hdr_nxt_idx;
            out_data_d = hdr_byte(hdr_nxt_idx);
            out_last_d = (hdr_nxt_idx == HDR_LAST) && (cnt_q == '0);
          end
        end
      end

      // fifo_read_request is high for this single cycle; data follows next cycle.
      RD_REQ: state_d = RD_WAIT;

      RD_WAIT: begin
        out_data_d  = fifo_q;
        out_valid_d = 1'b1;
        out_last_d  = (rem_q == LEN_W'(1));
        state_d     = DATA;
      end

      DATA: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          rem_d       = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d  = RD_REQ;
            rd_req_d = 1'b1;
          end
        end
      end

      FIN: state_d = IDLE;

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ts_lo_q     <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      hdr_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ts_lo_q     <= ts_lo_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      hdr_idx_q   <= hdr_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_req_q    <= rd_req_d;
    end
  end

  assign fifo_read_request = rd_req_q;
  assign out_data          = out_data_q;
  assign out_valid         = out_valid_q;
  assign out_last          = out_last_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_channel_readout.sv
// Randomised frame-level bench: a queue FIFO model feeds the DUT, a monitor
// collects transferred bytes, and each frame is compared with the expected frame.
module tb_channel_readout;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       readout_start = 1'b0;
  logic       echo_pulse_detected = 1'b0;
  logic [7:0] sample_length = '0;
  logic [12:0] timestamp = '0;
  logic [7:0] fifo_usdw = '0;
  logic [7:0] fifo_q = '0;
  logic       out_ready = 1'b1;
  logic       fifo_read_request, out_valid, out_last, busy, done;
  logic [7:0] out_data;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  channel_readout #(.HDR_BYTES(3), .FIFO_DEPTH(256)) dut (
    .clk(clk), .reset(reset), .readout_start(readout_start),
    .echo_pulse_detected(echo_pulse_detected), .sample_length(sample_length),
    .timestamp(timestamp), .fifo_usdw(fifo_usdw), .fifo_q(fifo_q),
    .fifo_read_request(fifo_read_request), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  // Non-showahead FIFO model.
  logic [7:0] fq[$];
  logic [7:0] pushed[$];
  int read_cnt = 0;
  always @(posedge clk) begin
    if (fifo_read_request) begin
      read_cnt++;
      if (fq.size() > 0) fifo_q <= fq.pop_front();
      else fifo_q <= 8'hEE;
    end
  end

  // Output monitor.
  logic [7:0] got_d[$];
  bit         got_l[$];
  int done_cnt = 0, busy_rise = 0, stall_err = 0;
  bit prev_stall = 0, prev_busy = 0, prev_last = 0;
  logic [7:0] prev_data = '0;
  always @(posedge clk) begin
    if (prev_stall && !(out_valid && out_data == prev_data && out_last == prev_last))
      stall_err++;
    if (out_last && !out_valid) stall_err++;
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
    if (done) done_cnt++;
    if (busy && !prev_busy) busy_rise++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    prev_busy  = busy;
  end

  task automatic check(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_d.delete();
    got_l.delete();
    done_cnt = 0;
    busy_rise = 0;
    stall_err = 0;
    read_cnt = 0;
    prev_stall = 0;
  endtask

  task automatic run_frame(input bit flag, input logic [12:0] ts, input int len,
                           input int nwords, input bit rnd_ready, input bit extra,
                           input string tag);
    int cnt, bad, nlast, lastpos;
    bit fin;
    logic [7:0] b;
    logic [7:0] exp[$];
    cnt = (len < nwords) ? len : nwords;
    fq.delete();
    pushed.delete();
    for (int i = 0; i < nwords; i++) begin
      b = 8'($urandom);
      fq.push_back(b);
      pushed.push_back(b);
    end
    exp.push_back({flag, 2'b00, ts[12:8]});
    exp.push_back(ts[7:0]);
    exp.push_back(8'(cnt));
    for (int i = 0; i < cnt; i++) exp.push_back(pushed[i]);

    @(negedge clk);
    clear_mon();
    echo_pulse_detected = flag;
    timestamp = ts;
    sample_length = 8'(len);
    fifo_usdw = 8'(nwords);
    out_ready = 1'b1;
    readout_start = 1'b1;
    fin = 0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(negedge clk);
      readout_start = 1'b0;
      if (c == 2) begin
        echo_pulse_detected = ~flag;
        timestamp = 13'($urandom);
        sample_length = 8'($urandom);
        fifo_usdw = 8'($urandom);
      end
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (extra && busy && (c % 4 == 1)) readout_start = 1'b1;
      if (done_cnt > 0) fin = 1;
    end
    readout_start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    check({tag, " completed"}, int'(fin), 1);
    check({tag, " frame_len"}, got_d.size(), 3 + cnt);
    bad = 0;
    nlast = 0;
    lastpos = -1;
    for (int i = 0; i < got_d.size(); i++) begin
      if (i >= exp.size() || got_d[i] !== exp[i]) bad++;
      if (got_l[i]) begin nlast++; lastpos = i; end
    end
    check({tag, " bad_bytes"}, bad, 0);
    if (got_d.size() > 0) check({tag, " byte0"}, int'(got_d[0]), int'(exp[0]));
    check({tag, " last_count"}, nlast, 1);
    check({tag, " last_pos"}, lastpos, 2 + cnt);
    check({tag, " reads"}, read_cnt, cnt);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " busy_rises"}, busy_rise, 1);
    check({tag, " stall_errs"}, stall_err, 0);
  endtask

  initial begin
    int nw, ln;
    bit seen;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_last", int'(out_last), 0);
    check("rst out_data", int'(out_data), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst rd_req", int'(fifo_read_request), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(1'b1, 13'h1ABC, 4, 4, 1'b0, 1'b0, "basic");
    run_frame(1'b0, 13'h0F35, 0, 5, 1'b0, 1'b0, "len0");
    run_frame(1'b1, 13'h0123, 255, 200, 1'b0, 1'b0, "len255");
    run_frame(1'b0, 13'h1FFF, 3, 10, 1'b1, 1'b0, "len_lt_usdw");
    for (int k = 0; k < 4; k++) begin
      nw = $urandom_range(0, 40);
      ln = $urandom_range(0, 40);
      run_frame(1'($urandom), 13'($urandom), ln, nw, 1'b1, 1'b0, "rand");
    end
    run_frame(1'b1, 13'h0ABC, 12, 12, 1'b1, 1'b1, "restart_ignored");

    // Abort mid-frame with reset while in the sample phase.
    fq.delete();
    for (int i = 0; i < 10; i++) fq.push_back(8'($urandom));
    @(negedge clk);
    clear_mon();
    sample_length = 8'd10;
    fifo_usdw = 8'd10;
    out_ready = 1'b1;
    readout_start = 1'b1;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      readout_start = 1'b0;
      if (read_cnt >= 3 && out_valid) seen = 1;
    end
    check("abort reached_data", int'(seen), 1);
    reset = 1'b0;
    @(negedge clk);
    check("abort out_valid", int'(out_valid), 0);
    check("abort out_last", int'(out_last), 0);
    check("abort out_data", int'(out_data), 0);
    check("abort busy", int'(busy), 0);
    check("abort rd_req", int'(fifo_read_request), 0);
    @(negedge clk);
    check("abort done", int'(done), 0);
    check("abort no_done_pulse", done_cnt, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(1'b0, 13'h1234, 6, 8, 1'b1, 1'b0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
